// File: rtl/mem_bus_pkg.sv
// Shared encodings for the core-side memory access controller:
// request sizes, response error codes, FSM states and the alignment rule.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_DECODE   = 2'b10,
      ERR_TIMEOUT  = 2'b11
   } err_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_e;

   // A request is misaligned when its low address bits do not fit its size;
   // the reserved size encoding is always treated as misaligned.
   function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = lane[0];
         SZ_WORD: is_misaligned = |lane;
         default: is_misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit RAM word and right-aligned core data:
// merges sub-word store data into an old word, and extracts/extends load data.
module mem_lane_align
   import mem_bus_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] store_data,
   input  size_e       size,
   input  logic [1:0]  lane,
   input  logic        sign_ext,
   output logic [31:0] merged,
   output logic [31:0] rdata
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Store path: overwrite only the addressed lanes, keep the rest of the old word.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      merged = word;
      case (size)
         SZ_BYTE: merged[{lane, 3'b000} +: 8]     = store_data[7:0];
         SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = store_data[15:0];
         default: merged = store_data;
      endcase
   end

   // Load path: pick the addressed lane, then zero- or sign-extend it.
   always_comb begin
      lane_byte = word[{lane, 3'b000} +: 8];
      lane_half = word[{lane[1], 4'b0000} +: 16];
      rdata     = word;
      case (size)
         SZ_BYTE: rdata = {{24{sign_ext & lane_byte[7]}}, lane_byte};
         SZ_HALF: rdata = {{16{sign_ext & lane_half[15]}}, lane_half};
         default: rdata = word;
      endcase
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Core-side memory access controller in front of a byte-addressed 32-bit RAM.
// One request at a time; sub-word stores are read-modify-write on the aligned
// word; misaligned, out-of-range and timed-out accesses return an error code.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter logic [23:0] RAM_BASE  = 24'h000000,
   parameter int unsigned RAM_BYTES = 512,
   parameter int unsigned TIMEOUT   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [23:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic [23:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_sel,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_e        state;
   logic [CW-1:0] wait_cnt;
   logic          r_we;
   size_e         r_size;
   logic          r_sign;
   logic [1:0]    r_lane;
   logic [31:0]   r_wdata;

   // Offset carries an extra top bit so an address below RAM_BASE wraps to a
   // huge value and fails the range check together with addresses past the end.
   logic [24:0]   offset;
   logic          misalign;
   logic          decode_err;
   logic          timed_out;
   logic [31:0]   merged;
   logic [31:0]   load_data;

   assign offset     = {1'b0, req_addr} - {1'b0, RAM_BASE};
   assign misalign   = is_misaligned(size_e'(req_size), req_addr[1:0]);
   assign decode_err = (offset >= 25'(RAM_BYTES));
   assign timed_out  = (wait_cnt == CW'(TIMEOUT - 1));

   mem_lane_align u_align (
      .word       (mem_rdata),
      .store_data (r_wdata),
      .size       (r_size),
      .lane       (r_lane),
      .sign_ext   (r_sign),
      .merged     (merged),
      .rdata      (load_data)
   );

   // Request FSM with registered RAM strobes and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         r_we      <= 1'b0;
         r_size    <= SZ_BYTE;
         r_sign    <= 1'b0;
         r_lane    <= 2'b00;
         r_wdata   <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= ERR_OK;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_write <= 1'b0;
         mem_sel   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  r_we      <= req_we;
                  r_size    <= size_e'(req_size);
                  r_sign    <= req_signed;
                  r_lane    <= req_addr[1:0];
                  r_wdata   <= req_wdata;
                  if (misalign) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= ERR_MISALIGN;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end else if (decode_err) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= ERR_DECODE;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end else begin
                     mem_addr <= offset[23:0] & 24'hFFFFFC;
                     mem_sel  <= 1'b1;
                     wait_cnt <= '0;
                     if (req_we && (size_e'(req_size) == SZ_WORD)) begin
                        mem_write <= 1'b1;
                        mem_wdata <= req_wdata;
                        state     <= WR;
                     end else begin
                        state <= RD;
                     end
                  end
               end
            end

            RD: begin
               if (mem_ready == 1'b1) begin
                  if (r_we) begin
                     mem_write <= 1'b1;
                     mem_wdata <= merged;
                     wait_cnt  <= '0;
                     state     <= WR;
                  end else begin
                     mem_sel   <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= ERR_OK;
                     rsp_rdata <= load_data;
                     state     <= RESP;
                  end
               end else if (timed_out) begin
                  mem_sel   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= ERR_TIMEOUT;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            WR: begin
               if (mem_ready == 1'b1) begin
                  mem_sel   <= 1'b0;
                  mem_write <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= ERR_OK;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else if (timed_out) begin
                  mem_sel   <= 1'b0;
                  mem_write <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= ERR_TIMEOUT;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            default: begin
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= ERR_OK;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl with a small byte-addressed
// RAM model (combinational read, write on an accepted ready edge).
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [23:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic [23:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic        mem_sel;
   logic [31:0] mem_rdata;
   wire         mem_ready;

   logic        ready_on = 1'b1;
   logic        preload = 1'b1;
   logic [31:0] ram [0:127];

   int checks = 0;
   int errors = 0;

   assign mem_ready = ready_on ? 1'b1 : 1'bz;
   assign mem_rdata = ram[mem_addr[8:2]];

   always #5 clk = ~clk;

   mem_bus_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_write  (mem_write),
      .mem_sel    (mem_sel),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   // RAM model: preload once, then write only on an edge with sel, write and a real 1 on ready.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 128; i++) ram[i] <= 32'h0;
         ram[1]   <= 32'h00000076;
         ram[2]   <= 32'h00000004;
         ram[5]   <= 32'hCAFEF00D;
         ram[6]   <= 32'h11223344;
         ram[8]   <= 32'h12345678;
         ram[127] <= 32'hA5A5A5A5;
      end else if (mem_sel && mem_write && ready_on) begin
         ram[mem_addr[8:2]] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one request and follow it to its response, counting strobe cycles.
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [23:0] addr, input logic [31:0] wdata,
                         output int lat, output int sel_n, output int wr_n,
                         output logic [31:0] wd, output logic [31:0] rd,
                         output logic [1:0] er);
      logic got;
      lat = 0; sel_n = 0; wr_n = 0; wd = '0; rd = '0; er = '0; got = 1'b0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (mem_sel) sel_n++;
         if (mem_write) begin
            wr_n++;
            wd = mem_wdata;
         end
         if (rsp_valid) begin
            rd  = rsp_rdata;
            er  = rsp_err;
            got = 1'b1;
            break;
         end
      end
      if (!got) check("rsp_bound", 32'd0, 32'd1);
   endtask

   task automatic load(input string tag, input logic [1:0] size, input logic sgn,
                       input logic [23:0] addr, input logic [31:0] exp_rd,
                       input logic [1:0] exp_er, input int exp_lat);
      int lat, sel_n, wr_n;
      logic [31:0] wd, rd;
      logic [1:0] er;
      do_req(1'b0, size, sgn, addr, 32'h0, lat, sel_n, wr_n, wd, rd, er);
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_err"}, 32'(er), 32'(exp_er));
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_sel"}, sel_n, (exp_er == 2'b00) ? 1 : 0);
   endtask

   task automatic store(input string tag, input logic [1:0] size, input logic [23:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_wd, input int exp_lat);
      int lat, sel_n, wr_n;
      logic [31:0] wd, rd;
      logic [1:0] er;
      do_req(1'b1, size, 1'b0, addr, data, lat, sel_n, wr_n, wd, rd, er);
      check({tag, "_wdata"}, wd, exp_wd);
      check({tag, "_err"}, 32'(er), 32'd0);
      check({tag, "_rdata"}, rd, 32'd0);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_wr"}, wr_n, 1);
      check({tag, "_sel"}, sel_n, exp_lat - 1);
   endtask

   initial begin
      int lat, sel_n, wr_n;
      logic [31:0] wd, rd;
      logic [1:0] er;

      repeat (3) @(posedge clk);
      #1 preload = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mem_sel", 32'(mem_sel), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;

      load("ld_w4", 2'b10, 1'b0, 24'h000004, 32'h00000076, 2'b00, 2);

      store("st_b9", 2'b00, 24'h000009, 32'h000000FF, 32'h0000FF04, 3);
      load("ld_w8", 2'b10, 1'b0, 24'h000008, 32'h0000FF04, 2'b00, 2);
      load("ld_bs9", 2'b00, 1'b1, 24'h000009, 32'hFFFFFFFF, 2'b00, 2);
      load("ld_bu9", 2'b00, 1'b0, 24'h000009, 32'h000000FF, 2'b00, 2);

      store("st_w10", 2'b10, 24'h000010, 32'hDEADBEEF, 32'hDEADBEEF, 2);
      load("ld_hs10", 2'b01, 1'b1, 24'h000010, 32'hFFFFBEEF, 2'b00, 2);
      load("ld_hs12", 2'b01, 1'b1, 24'h000012, 32'hFFFFDEAD, 2'b00, 2);
      load("ld_hu12", 2'b01, 1'b0, 24'h000012, 32'h0000DEAD, 2'b00, 2);
      load("ld_bs13", 2'b00, 1'b1, 24'h000013, 32'hFFFFFFDE, 2'b00, 2);
      load("ld_bu10", 2'b00, 1'b0, 24'h000010, 32'h000000EF, 2'b00, 2);

      store("st_h1a", 2'b01, 24'h00001A, 32'h0000ABCD, 32'hABCD3344, 3);
      load("ld_w18", 2'b10, 1'b0, 24'h000018, 32'hABCD3344, 2'b00, 2);

      load("mis_h5", 2'b01, 1'b0, 24'h000005, 32'h0, 2'b01, 1);
      load("mis_sz3", 2'b11, 1'b0, 24'h000000, 32'h0, 2'b01, 1);
      load("dec_200", 2'b10, 1'b0, 24'h000200, 32'h0, 2'b10, 1);
      load("prio_202", 2'b10, 1'b0, 24'h000202, 32'h0, 2'b01, 1);
      load("ld_w1fc", 2'b10, 1'b0, 24'h0001FC, 32'hA5A5A5A5, 2'b00, 2);

      // Word store with the RAM never ready: times out, nothing written.
      ready_on = 1'b0;
      do_req(1'b1, 2'b10, 1'b0, 24'h000014, 32'h11111111, lat, sel_n, wr_n, wd, rd, er);
      check("to_err", 32'(er), 32'd3);
      check("to_sel", sel_n, 32'd8);
      check("to_lat", lat, 32'd9);
      check("to_ram", ram[5], 32'hCAFEF00D);
      ready_on = 1'b1;
      load("to_ld14", 2'b10, 1'b0, 24'h000014, 32'hCAFEF00D, 2'b00, 2);

      // Reset in the middle of a word store must drop the write strobe at once.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 24'h000020;
      req_wdata = 32'h0BADF00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #1 check("rst_wr_before", 32'(mem_write), 32'd1);
      rst = 1'b1;
      #1 check("rst_wr_async", 32'(mem_write), 32'd0);
      check("rst_sel_async", 32'(mem_sel), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rst_ram20", ram[8], 32'h12345678);
      check("rst_req_ready2", 32'(req_ready), 32'd1);
      check("rst_rsp_valid2", 32'(rsp_valid), 32'd0);
      load("rst_ld20", 2'b10, 1'b0, 24'h000020, 32'h12345678, 2'b00, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
